layer_sequencer: RTL

- Sequences a chain of up to MAX_LAYERS runs of the shared linear layer engine, in place of host-driven starts.
- Holds a small descriptor table (activation/weight/bias/output base per layer) written by the host.
- Per layer: resets the engine, presents that layer's base addresses, pulses start, then waits for engine done.
- Counts engine out_valid pulses per layer as a sanity check; reports overall completion.

---
 rtl/nmca_pkg.sv | 17 +
 rtl/seq_desc_table.sv | 69 ++++++
 rtl/layer_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/nmca_pkg.sv
// rtl/nmca_pkg.sv - shared sequencer state encoding and descriptor field selects
package nmca_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ISSUE,
    WAIT,
    ADVANCE
  } seq_state_t;

  localparam logic [1:0] CFG_ACTIV  = 2'd0;
  localparam logic [1:0] CFG_WEIGHT = 2'd1;
  localparam logic [1:0] CFG_BIAS   = 2'd2;
  localparam logic [1:0] CFG_OUTPUT = 2'd3;

endpackage

// File: rtl/seq_desc_table.sv
// rtl/seq_desc_table.sv - per-layer base address register file, one write port, one async read port
module seq_desc_table
  import nmca_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_LAYERS = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [1:0]            wr_field,
  input  logic [ADDR_WIDTH-1:0] wr_data,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic [ADDR_WIDTH-1:0] rd_activ,
  output logic [ADDR_WIDTH-1:0] rd_weight,
  output logic [ADDR_WIDTH-1:0] rd_bias,
  output logic [ADDR_WIDTH-1:0] rd_output
);

  logic [ADDR_WIDTH-1:0] activ_q  [MAX_LAYERS];
  logic [ADDR_WIDTH-1:0] activ_d  [MAX_LAYERS];
  logic [ADDR_WIDTH-1:0] weight_q [MAX_LAYERS];
  logic [ADDR_WIDTH-1:0] weight_d [MAX_LAYERS];
  logic [ADDR_WIDTH-1:0] bias_q   [MAX_LAYERS];
  logic [ADDR_WIDTH-1:0] bias_d   [MAX_LAYERS];
  logic [ADDR_WIDTH-1:0] output_q [MAX_LAYERS];
  logic [ADDR_WIDTH-1:0] output_d [MAX_LAYERS];

  always_comb begin
    activ_d  = activ_q;
    weight_d = weight_q;
    bias_d   = bias_q;
    output_d = output_q;
    // Slots beyond MAX_LAYERS (non power-of-two tables) silently drop writes.
    if (wr_en && (int'(wr_idx) < MAX_LAYERS)) begin
      unique case (wr_field)
        CFG_ACTIV:  activ_d[wr_idx]  = wr_data;
        CFG_WEIGHT: weight_d[wr_idx] = wr_data;
        CFG_BIAS:   bias_d[wr_idx]   = wr_data;
        CFG_OUTPUT: output_d[wr_idx] = wr_data;
        default:    activ_d[wr_idx]  = activ_q[wr_idx];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        activ_q[i]  <= '0;
        weight_q[i] <= '0;
        bias_q[i]   <= '0;
        output_q[i] <= '0;
      end
    end else begin
      activ_q  <= activ_d;
      weight_q <= weight_d;
      bias_q   <= bias_d;
      output_q <= output_d;
    end
  end

  assign rd_activ  = activ_q[rd_idx];
  assign rd_weight = weight_q[rd_idx];
  assign rd_bias   = bias_q[rd_idx];
  assign rd_output = output_q[rd_idx];

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - chains linear layer engine runs from a host-written descriptor table
// Define SEQ_TIMEOUT_EN to add a per-layer watchdog that aborts a layer that never finishes.
module layer_sequencer
  import nmca_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int MAX_LAYERS     = 4,
  parameter int IDX_WIDTH      = 2,
  parameter int M              = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_WIDTH-1:0]  cfg_idx,
  input  logic [1:0]            cfg_field,
  input  logic [ADDR_WIDTH-1:0] cfg_data,
  input  logic [IDX_WIDTH:0]    num_layers,
  input  logic                  run,
  output logic                  busy,
  output logic                  all_done,
  output logic                  error,
  output logic [IDX_WIDTH-1:0]  cur_layer,
  output logic                  layer_rst,
  output logic                  layer_start,
  output logic [ADDR_WIDTH-1:0] activ_base,
  output logic [ADDR_WIDTH-1:0] weight_base,
  output logic [ADDR_WIDTH-1:0] bias_base,
  output logic [ADDR_WIDTH-1:0] output_base,
  input  logic                  layer_done,
  input  logic                  layer_out_valid
);

  localparam int CntW = $clog2(M + 2);
  localparam logic [CntW-1:0] CntSat = CntW'(M + 1);
  localparam logic [CntW-1:0] CntExp = CntW'(M);

  if (IDX_WIDTH != $clog2(MAX_LAYERS) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("layer_sequencer: inconsistent parameters");
  end

  seq_state_t state_q, state_d;
  logic [IDX_WIDTH-1:0]  cur_q, cur_d;
  logic [IDX_WIDTH:0]    count_q, count_d;
  logic                  busy_q, busy_d;
  logic                  all_done_q, all_done_d;
  logic                  error_q, error_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0] activ_q, activ_d, weight_q, weight_d;
  logic [ADDR_WIDTH-1:0] bias_q, bias_d, output_q, output_d;
  logic [ADDR_WIDTH-1:0] rd_activ, rd_weight, rd_bias, rd_output;
  logic                  run_ok;

`ifdef SEQ_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  seq_desc_table #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_LAYERS(MAX_LAYERS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_desc_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cfg_we),
    .wr_idx   (cfg_idx),
    .wr_field (cfg_field),
    .wr_data  (cfg_data),
    .rd_idx   (cur_q),
    .rd_activ (rd_activ),
    .rd_weight(rd_weight),
    .rd_bias  (rd_bias),
    .rd_output(rd_output)
  );

  assign run_ok  = (num_layers != '0) && (int'(num_layers) <= MAX_LAYERS);
  // A pulse arriving together with layer_done must be part of the compare.
  assign cnt_inc = cnt_q + CntW'(layer_out_valid && (cnt_q != CntSat));

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    count_d    = count_q;
    busy_d     = busy_q;
    all_done_d = 1'b0;
    error_d    = error_q;
    cnt_d      = cnt_q;
    activ_d    = activ_q;
    weight_d   = weight_q;
    bias_d     = bias_q;
    output_d   = output_q;
`ifdef SEQ_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (run) begin
          if (run_ok) begin
            count_d = num_layers;
            cur_d   = '0;
            busy_d  = 1'b1;
            error_d = 1'b0;
            state_d = CLR;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      CLR: begin
        activ_d  = rd_activ;
        weight_d = rd_weight;
        bias_d   = rd_bias;
        output_d = rd_output;
        cnt_d    = '0;
`ifdef SEQ_TIMEOUT_EN
        tmo_d    = '0;
`endif
        state_d  = ISSUE;
      end
      ISSUE: begin
`ifdef SEQ_TIMEOUT_EN
        tmo_d   = tmo_q + TmoW'(1);
`endif
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
`ifdef SEQ_TIMEOUT_EN
        tmo_d = tmo_q + TmoW'(1);
        if (!layer_done && (tmo_q == TmoLast)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else
`endif
        if (layer_done) begin
          if (cnt_inc != CntExp) error_d = 1'b1;
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        if ({1'b0, cur_q} == count_q - (IDX_WIDTH + 1)'(1)) begin
          all_done_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          cur_d   = cur_q + IDX_WIDTH'(1);
          state_d = CLR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      activ_q    <= '0;
      weight_q   <= '0;
      bias_q     <= '0;
      output_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      all_done_q <= all_done_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
      activ_q    <= activ_d;
      weight_q   <= weight_d;
      bias_q     <= bias_d;
      output_q   <= output_d;
`ifdef SEQ_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Decoded from state so the async reset forces the engine reset immediately.
  assign layer_rst   = (state_q == IDLE) || (state_q == CLR);
  assign layer_start = (state_q == ISSUE);
  assign busy        = busy_q;
  assign all_done    = all_done_q;
  assign error       = error_q;
  assign cur_layer   = cur_q;
  assign activ_base  = activ_q;
  assign weight_base = weight_q;
  assign bias_base   = bias_q;
  assign output_base = output_q;

endmodule
